// File: rtl/ctrlr_if_pkg.sv
// Shared constants and types for the serial game-pad responder.
// Pad count, bits per pad and FSM state encoding live here.
package ctrlr_if_pkg;

  localparam int CTRLR_BITS = 12;
  localparam int NUM_CTRLRS = 4;
  localparam int IDX_W      = $clog2(CTRLR_BITS);

  typedef logic [CTRLR_BITS-1:0] pad_word_t;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_PULSE  = 3'd3,
    ST_UPDATE = 3'd4
  } ctrlr_state_t;

endpackage

// File: rtl/ctrlr_if_if.sv
// Read port between the memory controller (master) and the pad responder (slave).
// Pure combinational read: select and enable in, held button word out.
interface ctrlr_if_if;
  import ctrlr_if_pkg::*;

  logic      ctrlr_re;
  logic [1:0] addr_ctrlr;
  pad_word_t dout_ctrlr;

  modport master (output ctrlr_re, output addr_ctrlr, input dout_ctrlr);
  modport slave  (input ctrlr_re, input addr_ctrlr, output dout_ctrlr);

endinterface

// File: rtl/ctrlr_tick_gen.sv
// Divides clk by CLK_DIV into a one-cycle tick strobe (count 0..CLK_DIV-1, tick on the last).
// The count freezes while en is low so the FSM can insert single-clock states.
module ctrlr_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == CNT_MAX);

endmodule

// File: rtl/ctrlr_if.sv
// Polls four SNES-style pads over a shared latch/clock pair and holds the last complete frame.
// Reads are combinational; held words change atomically one clock after frame_done.
module ctrlr_if
  import ctrlr_if_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int POLL_PERIOD = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  ctrlr_if_if.slave             bus,
  output logic                  ctrlr_latch,
  output logic                  ctrlr_clk,
  input  logic [NUM_CTRLRS-1:0] ctrlr_data,
  output logic                  frame_done
);

  localparam int WAIT_W = $clog2(POLL_PERIOD + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CTRLR_BITS - 1);

  ctrlr_state_t      state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              latch_ph;
  logic [IDX_W-1:0]  idx;
  logic              tick;
  pad_word_t         shift_reg [NUM_CTRLRS];
  pad_word_t         held      [NUM_CTRLRS];

  // UPDATE is a single clock; freezing the divider there keeps tick phase intact
  // and makes the frame period a whole number of ticks plus one clock.
  ctrlr_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state != ST_UPDATE),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_WAIT;
      wait_cnt    <= '0;
      latch_ph    <= 1'b0;
      idx         <= '0;
      ctrlr_latch <= 1'b0;
      ctrlr_clk   <= 1'b1;
      frame_done  <= 1'b0;
      for (int p = 0; p < NUM_CTRLRS; p++) begin
        shift_reg[p] <= '0;
        held[p]      <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_WAIT: begin
          if (tick) begin
            if (wait_cnt <= WAIT_W'(1)) begin
              state       <= ST_LATCH;
              ctrlr_latch <= 1'b1;
              latch_ph    <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt - WAIT_W'(1);
            end
          end
        end
        ST_LATCH: begin
          if (tick) begin
            if (latch_ph) begin
              state       <= ST_SAMPLE;
              ctrlr_latch <= 1'b0;
              idx         <= '0;
            end else begin
              latch_ph <= 1'b1;
            end
          end
        end
        ST_SAMPLE: begin
          if (tick) begin
            // Pads drive active-low; store as 1 = pressed.
            for (int p = 0; p < NUM_CTRLRS; p++) begin
              shift_reg[p][idx] <= ~ctrlr_data[p];
            end
            if (idx == LAST_IDX) begin
              state      <= ST_UPDATE;
              frame_done <= 1'b1;
            end else begin
              state     <= ST_PULSE;
              ctrlr_clk <= 1'b0;
            end
          end
        end
        ST_PULSE: begin
          if (tick) begin
            state     <= ST_SAMPLE;
            ctrlr_clk <= 1'b1;
            idx       <= idx + IDX_W'(1);
          end
        end
        ST_UPDATE: begin
          for (int p = 0; p < NUM_CTRLRS; p++) begin
            held[p] <= shift_reg[p];
          end
          wait_cnt <= WAIT_W'(POLL_PERIOD);
          state    <= ST_WAIT;
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

  assign bus.dout_ctrlr = bus.ctrlr_re ? held[bus.addr_ctrlr] : '0;

endmodule

// File: tb/tb_ctrlr_if.sv
// Bench for ctrlr_if: behavioural SNES pads, table-driven frame vectors, and directed
// sequences for pin waveform, update collision and mid-frame reset.
module tb_ctrlr_if;
  import ctrlr_if_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ctrlr_data;
  logic       ctrlr_latch;
  logic       ctrlr_clk;
  logic       frame_done;

  ctrlr_if_if bus ();

  ctrlr_if #(.CLK_DIV(4), .POLL_PERIOD(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .ctrlr_latch (ctrlr_latch),
    .ctrlr_clk   (ctrlr_clk),
    .ctrlr_data  (ctrlr_data),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pad model: latch reloads bit 0, each rising ctrlr_clk advances to the next bit.
  logic [11:0] pat [4];
  int          pad_idx   = 0;
  logic        prev_cclk = 1'b1;

  always @(posedge clk) begin
    if (ctrlr_latch) pad_idx <= 0;
    else if (!prev_cclk && ctrlr_clk) pad_idx <= pad_idx + 1;
    prev_cclk <= ctrlr_clk;
  end

  always_comb begin
    ctrlr_data = 4'hF;
    for (int p = 0; p < 4; p++) begin
      if (pad_idx < 12) ctrlr_data[p] = ~pat[p][pad_idx[3:0]];
    end
  end

  // Pin activity counters; frame measurements are differences between snapshots.
  int   lat_pulses = 0, lat_cyc = 0, clk_pulses = 0, clk_cyc = 0;
  logic mon_lat = 1'b0, mon_clk = 1'b1;

  always @(posedge clk) begin
    if (!reset) begin
      if (ctrlr_latch) lat_cyc <= lat_cyc + 1;
      if (ctrlr_latch && !mon_lat) lat_pulses <= lat_pulses + 1;
      if (!ctrlr_clk) clk_cyc <= clk_cyc + 1;
      if (!ctrlr_clk && mon_clk) clk_pulses <= clk_pulses + 1;
    end
    mon_lat <= ctrlr_latch;
    mon_clk <= ctrlr_clk;
  end

  typedef struct {
    logic [11:0] pats [4];
    logic [11:0] exp  [4];
  } vec_t;

  vec_t vecs [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic re, input logic [1:0] a, output logic [11:0] d);
    bus.ctrlr_re   = re;
    bus.addr_ctrlr = a;
    #1;
    d = bus.dout_ctrlr;
  endtask

  task automatic wait_fd(input string name);
    int n;
    n = 0;
    while (!frame_done && n < 600) begin
      next_cycle();
      n++;
    end
    if (!frame_done) begin
      checks++;
      errors++;
      $display("FAIL %s: frame_done timeout, got none, expected pulse within 600 cycles", name);
    end
  endtask

  initial begin
    logic [11:0] d;
    int base, fd_prev, s_lp, s_lc, s_cp, s_cc;

    for (int p = 0; p < 4; p++) pat[p] = 12'h000;
    vecs[0].pats = '{12'hA5C, 12'h000, 12'h000, 12'h000};
    vecs[0].exp  = '{12'hA5C, 12'h000, 12'h000, 12'h000};
    vecs[1].pats = '{12'h001, 12'h800, 12'hFFF, 12'h555};
    vecs[1].exp  = '{12'h001, 12'h800, 12'hFFF, 12'h555};

    reset          = 1'b1;
    bus.ctrlr_re   = 1'b1;
    bus.addr_ctrlr = 2'd0;

    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("reset_latch", 32'(ctrlr_latch), 32'd0);
      check("reset_clk", 32'(ctrlr_clk), 32'd1);
      check("reset_frame_done", 32'(frame_done), 32'd0);
      check("reset_dout", 32'(bus.dout_ctrlr), 32'd0);
    end

    reset   = 1'b0;
    base    = cyc;
    fd_prev = 0;
    s_lp = 0; s_lc = 0; s_cp = 0; s_cc = 0;

    for (int v = 0; v < 2; v++) begin
      for (int p = 0; p < 4; p++) pat[p] = vecs[v].pats[p];
      wait_fd("vec_frame");
      if (v == 0) begin
        check("first_frame_cycle", 32'(cyc - base), 32'd104);
      end else begin
        check("frame_period_cycles", 32'(cyc - fd_prev), 32'd133);
        check("latch_pulses", 32'(lat_pulses - s_lp), 32'd1);
        check("latch_high_cycles", 32'(lat_cyc - s_lc), 32'd8);
        check("clk_low_pulses", 32'(clk_pulses - s_cp), 32'd11);
        check("clk_low_cycles", 32'(clk_cyc - s_cc), 32'd44);
      end
      fd_prev = cyc;
      next_cycle();
      s_lp = lat_pulses; s_lc = lat_cyc; s_cp = clk_pulses; s_cc = clk_cyc;
      check("frame_done_one_cycle", 32'(frame_done), 32'd0);
      for (int a = 0; a < 4; a++) begin
        rd(1'b1, 2'(a), d);
        check("vec_read", 32'(d), 32'(vecs[v].exp[a]));
      end
      rd(1'b0, 2'd2, d);
      check("read_disabled", 32'(d), 32'd0);
    end

    // Update collision: same-cycle read returns the previous frame.
    for (int p = 0; p < 4; p++) pat[p] = 12'h000;
    pat[0] = 12'h0F0;
    wait_fd("collision_f1");
    rd(1'b1, 2'd0, d);
    check("collision_f1_old", 32'(d), 32'h001);
    pat[0] = 12'h00F;
    next_cycle();
    rd(1'b1, 2'd0, d);
    check("collision_f1_new", 32'(d), 32'h0F0);
    wait_fd("collision_f2");
    rd(1'b1, 2'd0, d);
    check("collision_same_cycle", 32'(d), 32'h0F0);
    next_cycle();
    rd(1'b1, 2'd0, d);
    check("collision_next_cycle", 32'(d), 32'h00F);

    // Mid-frame reset while sampling bit 5.
    begin
      int n;
      n = 0;
      while (!(pad_idx == 5 && ctrlr_clk && !ctrlr_latch) && n < 600) begin
        next_cycle();
        n++;
      end
      check("reach_sample5", 32'(pad_idx), 32'd5);
    end
    pat[0] = 12'h3C3;
    pat[3] = 12'h924;
    reset  = 1'b1;
    next_cycle();
    check("midrst_latch", 32'(ctrlr_latch), 32'd0);
    check("midrst_clk", 32'(ctrlr_clk), 32'd1);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(1'b1, 2'(a), d);
      check("midrst_held_clear", 32'(d), 32'd0);
    end
    reset = 1'b0;
    base  = cyc;
    wait_fd("midrst_frame");
    check("midrst_frame_cycle", 32'(cyc - base), 32'd104);
    next_cycle();
    rd(1'b1, 2'd0, d);
    check("midrst_pad0", 32'(d), 32'h3C3);
    rd(1'b1, 2'd1, d);
    check("midrst_pad1", 32'(d), 32'h000);
    rd(1'b1, 2'd3, d);
    check("midrst_pad3", 32'(d), 32'h924);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
